// File: rtl/airlock_if.sv
// Request/status bundle between the user-input pulse generators, the airlock
// sequencer and the display logic.
interface airlock_if #(
   parameter int CNT_W = 4,
   parameter int OCC_W = 2
);
   logic             fill_req;
   logic             evac_req;
   logic             outer_open_req;
   logic             inner_open_req;
   logic             boat_in;
   logic             boat_out;
   logic             outer_open;
   logic             inner_open;
   logic             filling;
   logic             evacuating;
   logic [CNT_W-1:0] countdown;
   logic [2:0]       state_code;
   logic [OCC_W-1:0] occupancy;
   logic             occ_full;
   logic             reject;

   modport master (
      output fill_req, evac_req, outer_open_req, inner_open_req, boat_in, boat_out,
      input  outer_open, inner_open, filling, evacuating, countdown, state_code,
             occupancy, occ_full, reject
   );

   modport slave (
      input  fill_req, evac_req, outer_open_req, inner_open_req, boat_in, boat_out,
      output outer_open, inner_open, filling, evacuating, countdown, state_code,
             occupancy, occ_full, reject
   );
endinterface

// File: rtl/airlock_sequencer.sv
// Chamber controller: timed fill/evacuate with abort-and-reverse, door
// interlock, saturating occupancy count and a registered reject pulse.
module airlock_sequencer #(
   parameter int FILL_CYCLES = 7,
   parameter int EVAC_CYCLES = 8,
   parameter int CNT_W       = 4,
   parameter int MAX_OCC     = 2,
   parameter int OCC_W       = 2
) (
   input logic      clock,
   input logic      reset,
   airlock_if.slave bus
);
   typedef enum logic [2:0] {
      LOW_IDLE   = 3'd0,
      OUTER_OPEN = 3'd1,
      FILLING    = 3'd2,
      HIGH_IDLE  = 3'd3,
      INNER_OPEN = 3'd4,
      EVACUATING = 3'd5
   } state_t;

   localparam logic [CNT_W-1:0] FILL_TOP = CNT_W'(FILL_CYCLES - 1);
   localparam logic [CNT_W-1:0] EVAC_TOP = CNT_W'(EVAC_CYCLES - 1);
   localparam logic [OCC_W-1:0] OCC_MAX  = OCC_W'(MAX_OCC);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, elapsed;
   logic [OCC_W-1:0] occ_q, occ_d;
   logic             rej_q, rej_d;
   logic             outer_q, inner_q, fill_q, evac_q, full_q;
   logic             door_open;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= LOW_IDLE;
         cnt_q   <= '0;
         occ_q   <= '0;
         rej_q   <= 1'b0;
         outer_q <= 1'b0;
         inner_q <= 1'b0;
         fill_q  <= 1'b0;
         evac_q  <= 1'b0;
         full_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         occ_q   <= occ_d;
         rej_q   <= rej_d;
         outer_q <= (state_d == OUTER_OPEN);
         inner_q <= (state_d == INNER_OPEN);
         fill_q  <= (state_d == FILLING);
         evac_q  <= (state_d == EVACUATING);
         full_q  <= (occ_d == OCC_MAX);
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      occ_d     = occ_q;
      rej_d     = 1'b0;
      elapsed   = '0;
      door_open = (state_q == OUTER_OPEN) || (state_q == INNER_OPEN);

      case (state_q)
         LOW_IDLE: begin
            if (bus.outer_open_req) begin
               state_d = OUTER_OPEN;
               if (bus.fill_req) rej_d = 1'b1;
            end else if (bus.fill_req) begin
               state_d = FILLING;
               cnt_d   = FILL_TOP;
            end
            if (bus.evac_req) rej_d = 1'b1;
         end
         OUTER_OPEN: begin
            if (!bus.outer_open_req) state_d = LOW_IDLE;
            if (bus.fill_req || bus.evac_req) rej_d = 1'b1;
         end
         FILLING: begin
            // Reversal runs back over the time already spent filling.
            if (bus.evac_req) begin
               elapsed = FILL_TOP - cnt_q;
               state_d = EVACUATING;
               cnt_d   = (elapsed < EVAC_TOP) ? elapsed : EVAC_TOP;
            end else if (cnt_q == '0) begin
               state_d = HIGH_IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
            if (bus.fill_req) rej_d = 1'b1;
         end
         HIGH_IDLE: begin
            if (bus.inner_open_req) begin
               state_d = INNER_OPEN;
               if (bus.evac_req) rej_d = 1'b1;
            end else if (bus.evac_req) begin
               state_d = EVACUATING;
               cnt_d   = EVAC_TOP;
            end
            if (bus.fill_req) rej_d = 1'b1;
         end
         INNER_OPEN: begin
            if (!bus.inner_open_req) state_d = HIGH_IDLE;
            if (bus.fill_req || bus.evac_req) rej_d = 1'b1;
         end
         EVACUATING: begin
            if (bus.fill_req) begin
               elapsed = EVAC_TOP - cnt_q;
               state_d = FILLING;
               cnt_d   = (elapsed < FILL_TOP) ? elapsed : FILL_TOP;
            end else if (cnt_q == '0) begin
               state_d = LOW_IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
            if (bus.evac_req) rej_d = 1'b1;
         end
         default: begin
            state_d = LOW_IDLE;
            cnt_d   = '0;
         end
      endcase

      if (!door_open) begin
         if (bus.boat_in || bus.boat_out) rej_d = 1'b1;
      end else if (bus.boat_in && !bus.boat_out) begin
         if (occ_q == OCC_MAX) rej_d = 1'b1;
         else                  occ_d = occ_q + 1'b1;
      end else if (bus.boat_out && !bus.boat_in) begin
         if (occ_q == '0) rej_d = 1'b1;
         else             occ_d = occ_q - 1'b1;
      end
   end

   assign bus.state_code = state_q;
   assign bus.countdown  = cnt_q;
   assign bus.occupancy  = occ_q;
   assign bus.reject     = rej_q;
   assign bus.outer_open = outer_q;
   assign bus.inner_open = inner_q;
   assign bus.filling    = fill_q;
   assign bus.evacuating = evac_q;
   assign bus.occ_full   = full_q;
endmodule

// File: tb/tb_airlock_sequencer.sv
// Self-checking bench for airlock_sequencer: vector table, directed corner
// sequences and a random request storm against a progress-based model.
module tb_airlock_sequencer;
   localparam int FILL = 7;
   localparam int EVAC = 8;
   localparam int CW   = 4;
   localparam int OW   = 2;
   localparam int MAXO = 2;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   airlock_if #(.CNT_W(CW), .OCC_W(OW)) bus ();

   airlock_sequencer #(
      .FILL_CYCLES(FILL),
      .EVAC_CYCLES(EVAC),
      .CNT_W(CW),
      .MAX_OCC(MAXO),
      .OCC_W(OW)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus(bus)
   );

   int errors = 0;
   int checks = 0;

   // Model: chamber described by doors, remaining cycles of a timed op and level.
   bit m_outer, m_inner, m_high, m_rej;
   int m_fill_left, m_evac_left, m_occ;

   typedef struct {
      bit f, e, o, i, bi, bo;
      int st, cnt, occ;
      bit rej;
   } vec_t;
   vec_t tbl[17];

   task automatic chk(input string name, input logic [31:0] act, input int exp);
      checks++;
      if (act !== 32'(exp)) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int mmin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   task automatic model_reset();
      m_outer = 0; m_inner = 0; m_high = 0; m_rej = 0;
      m_fill_left = 0; m_evac_left = 0; m_occ = 0;
   endtask

   task automatic model_step();
      bit f, e, o, i, bi, bo;
      f = bus.fill_req; e = bus.evac_req; o = bus.outer_open_req;
      i = bus.inner_open_req; bi = bus.boat_in; bo = bus.boat_out;
      m_rej = 0;
      if (m_outer || m_inner) begin
         if (bi && !bo) begin
            if (m_occ == MAXO) m_rej = 1; else m_occ++;
         end else if (bo && !bi) begin
            if (m_occ == 0) m_rej = 1; else m_occ--;
         end
      end else if (bi || bo) m_rej = 1;

      if (m_fill_left > 0) begin
         if (f) m_rej = 1;
         if (e) begin
            m_evac_left = mmin(FILL - m_fill_left, EVAC - 1) + 1;
            m_fill_left = 0;
         end else begin
            m_fill_left--;
            if (m_fill_left == 0) m_high = 1;
         end
      end else if (m_evac_left > 0) begin
         if (e) m_rej = 1;
         if (f) begin
            m_fill_left = mmin(EVAC - m_evac_left, FILL - 1) + 1;
            m_evac_left = 0;
         end else begin
            m_evac_left--;
            if (m_evac_left == 0) m_high = 0;
         end
      end else if (m_outer) begin
         if (!o) m_outer = 0;
         if (f || e) m_rej = 1;
      end else if (m_inner) begin
         if (!i) m_inner = 0;
         if (f || e) m_rej = 1;
      end else if (!m_high) begin
         if (o) begin m_outer = 1; if (f) m_rej = 1; end
         else if (f) m_fill_left = FILL;
         if (e) m_rej = 1;
      end else begin
         if (i) begin m_inner = 1; if (e) m_rej = 1; end
         else if (e) m_evac_left = EVAC;
         if (f) m_rej = 1;
      end
   endtask

   function automatic logic [14:0] exp_vec();
      int st, cnt;
      st  = m_outer ? 1 : m_inner ? 4 : (m_fill_left > 0) ? 2 : (m_evac_left > 0) ? 5 : m_high ? 3 : 0;
      cnt = (m_fill_left > 0) ? m_fill_left - 1 : (m_evac_left > 0) ? m_evac_left - 1 : 0;
      return {3'(st), 4'(cnt), 2'(m_occ), m_outer, m_inner, m_fill_left > 0,
              m_evac_left > 0, m_occ == MAXO, m_rej};
   endfunction

   function automatic logic [14:0] dut_vec();
      return {bus.state_code, bus.countdown, bus.occupancy, bus.outer_open, bus.inner_open,
              bus.filling, bus.evacuating, bus.occ_full, bus.reject};
   endfunction

   task automatic drive(input bit f, e, o, i, bi, bo);
      bus.fill_req = f; bus.evac_req = e; bus.outer_open_req = o;
      bus.inner_open_req = i; bus.boat_in = bi; bus.boat_out = bo;
   endtask

   task automatic step(input bit f, e, o, i, bi, bo);
      drive(f, e, o, i, bi, bo);
      @(posedge clock);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      drive(0, 0, 0, 0, 0, 0);
      @(negedge clock);
      reset = 1'b0;
      model_reset();
      #1;
      chk("reset_outputs", 32'(dut_vec()), 0);
      @(negedge clock);
      reset = 1'b1;
   endtask

   initial begin
      bit o_lvl, i_lvl;
      //          f e o i bi bo  st cnt occ rej
      tbl[0]  = '{1,0,1,0,0,0, 1, 0, 0, 1};
      tbl[1]  = '{0,0,1,1,0,0, 1, 0, 0, 0};
      tbl[2]  = '{0,0,1,0,1,0, 1, 0, 1, 0};
      tbl[3]  = '{0,0,1,0,1,0, 1, 0, 2, 0};
      tbl[4]  = '{0,0,1,0,1,0, 1, 0, 2, 1};
      tbl[5]  = '{0,0,1,0,1,1, 1, 0, 2, 0};
      tbl[6]  = '{0,0,1,0,0,1, 1, 0, 1, 0};
      tbl[7]  = '{0,0,0,0,0,0, 0, 0, 1, 0};
      tbl[8]  = '{0,0,0,0,0,1, 0, 0, 1, 1};
      tbl[9]  = '{0,1,0,0,0,0, 0, 0, 1, 1};
      tbl[10] = '{1,0,0,0,0,0, 2, 6, 1, 0};
      tbl[11] = '{0,0,0,0,0,0, 2, 5, 1, 0};
      tbl[12] = '{1,0,0,0,0,0, 2, 4, 1, 1};
      tbl[13] = '{0,0,0,0,0,0, 2, 3, 1, 0};
      tbl[14] = '{0,1,0,0,0,0, 5, 3, 1, 0};
      tbl[15] = '{0,1,0,0,0,0, 5, 2, 1, 1};
      tbl[16] = '{1,0,0,0,0,0, 2, 5, 1, 0};

      drive(0, 0, 0, 0, 0, 0);
      do_reset();

      foreach (tbl[k]) begin
         step(tbl[k].f, tbl[k].e, tbl[k].o, tbl[k].i, tbl[k].bi, tbl[k].bo);
         chk($sformatf("tbl%0d_state", k), 32'(bus.state_code), tbl[k].st);
         chk($sformatf("tbl%0d_cnt", k), 32'(bus.countdown), tbl[k].cnt);
         chk($sformatf("tbl%0d_occ", k), 32'(bus.occupancy), tbl[k].occ);
         chk($sformatf("tbl%0d_rej", k), 32'(bus.reject), int'(tbl[k].rej));
         chk($sformatf("tbl%0d_outer", k), 32'(bus.outer_open), int'(tbl[k].st == 1));
         chk($sformatf("tbl%0d_full", k), 32'(bus.occ_full), int'(tbl[k].occ == MAXO));
      end

      // Full fill lasts exactly FILL cycles, then high side idle; then inner side.
      do_reset();
      step(1, 0, 0, 0, 0, 0);
      for (int n = 0; n < FILL; n++) begin
         chk("fill_active", 32'(bus.filling), 1);
         chk("fill_cnt", 32'(bus.countdown), FILL - 1 - n);
         step(0, 0, 0, 0, 0, 0);
      end
      chk("fill_done_state", 32'(bus.state_code), 3);
      chk("fill_done_flag", 32'(bus.filling), 0);
      step(0, 1, 0, 1, 0, 0);
      chk("inner_prio_state", 32'(bus.state_code), 4);
      chk("inner_prio_rej", 32'(bus.reject), 1);
      chk("inner_prio_evac", 32'(bus.evacuating), 0);
      step(0, 0, 0, 1, 1, 0);
      chk("inner_boat_occ", 32'(bus.occupancy), 1);
      step(0, 0, 0, 0, 0, 0);
      chk("inner_close", 32'(bus.state_code), 3);
      step(0, 1, 0, 0, 0, 0);
      chk("evac_start_cnt", 32'(bus.countdown), EVAC - 1);

      // Abort a fill with countdown 2 and run the reversal to the low side.
      do_reset();
      step(1, 0, 0, 0, 0, 0);
      repeat (4) step(0, 0, 0, 0, 0, 0);
      chk("abort_pre_cnt", 32'(bus.countdown), 2);
      step(0, 1, 0, 0, 0, 0);
      chk("abort_evac", 32'(bus.evacuating), 1);
      chk("abort_cnt", 32'(bus.countdown), 4);
      for (int n = 0; n < 5; n++) begin
         step(0, 0, 0, 0, 0, 0);
         chk("abort_return", 32'(bus.state_code), (n == 4) ? 0 : 5);
      end

      // Reset asserted mid-fill clears everything before the next edge.
      do_reset();
      step(0, 0, 1, 0, 0, 0);
      step(0, 0, 1, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      repeat (3) step(0, 0, 0, 0, 0, 0);
      chk("midfill_cnt", 32'(bus.countdown), 3);
      chk("midfill_occ", 32'(bus.occupancy), 1);
      reset = 1'b0;
      #1;
      chk("async_state", 32'(bus.state_code), 0);
      chk("async_cnt", 32'(bus.countdown), 0);
      chk("async_fill", 32'(bus.filling), 0);
      chk("async_occ", 32'(bus.occupancy), 0);
      @(negedge clock);
      reset = 1'b1;

      // Random request storm against the model.
      do_reset();
      o_lvl = 0;
      i_lvl = 0;
      for (int n = 0; n < 10000; n++) begin
         if ($urandom_range(0, 9) == 0) o_lvl = ~o_lvl;
         if ($urandom_range(0, 9) == 0) i_lvl = ~i_lvl;
         step($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, o_lvl, i_lvl,
              $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
         chk("rand_outputs", 32'(dut_vec()), int'(exp_vec()));
         chk("rand_both_open", 32'(bus.outer_open && bus.inner_open), 0);
         chk("rand_open_moving", 32'((bus.outer_open || bus.inner_open) &&
                                     (bus.filling || bus.evacuating)), 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/airlock_sequencer.md
Name: airlock_sequencer

Overview:
- Parametrised chamber controller for the lock/interlock system.
- Sequences fill/pressurize and evacuate with programmable durations and enforces the door interlock: never both ports open, and a port opens only when chamber pressure matches its side.
- Adds abort-and-reverse of a running pressure cycle, a saturating chamber occupancy counter and a reject pulse.
- Sits between the one-clock user-input pulse generators and the LED/HEX display logic.

Parameters:
- FILL_CYCLES, 7, clock cycles needed to fill/pressurize (>=1).
- EVAC_CYCLES, 8, clock cycles needed to evacuate (>=1).
- CNT_W, 4, countdown width; 2^CNT_W must exceed max(FILL_CYCLES, EVAC_CYCLES).
- MAX_OCC, 2, chamber occupancy limit (>=1).
- OCC_W, 2, occupancy width; 2^OCC_W must exceed MAX_OCC.

Ports:
- clock  in  1  system clock (divided clock).
- reset  in  1  asynchronous, active-low reset.
- fill_req  in  1  single-cycle pulse requesting fill/pressurize.
- evac_req  in  1  single-cycle pulse requesting evacuation.
- outer_open_req  in  1  level; 1 = operator wants outer port open.
- inner_open_req  in  1  level; 1 = operator wants inner port open.
- boat_in  in  1  single-cycle pulse; a boat entered the chamber.
- boat_out  in  1  single-cycle pulse; a boat left the chamber.
- outer_open  out  1  outer port open command.
- inner_open  out  1  inner port open command.
- filling  out  1  fill/pressurize in progress.
- evacuating  out  1  evacuation in progress.
- countdown  out  CNT_W  cycles remaining in the current timed operation.
- state_code  out  3  current state, encoded as listed under Behaviour.
- occupancy  out  OCC_W  boats in the chamber.
- occ_full  out  1  occupancy == MAX_OCC.
- reject  out  1  one-cycle pulse when a request or event is refused.

Behaviour:
- Outputs:
  - All outputs are registered (Moore).
  - A request sampled at edge k is reflected in the outputs after edge k.
- Reset (async, reset==0):
  - State goes to LOW_IDLE; countdown=0, occupancy=0.
  - All 1-bit outputs = 0.
  - Reset asserted mid-operation aborts any fill/evacuate immediately.
- States, with state_code and the outputs driven in each:
  - LOW_IDLE=0: both ports closed, chamber at outer level.
  - OUTER_OPEN=1: outer_open=1.
  - FILLING=2: filling=1.
  - HIGH_IDLE=3: both ports closed, chamber at inner level.
  - INNER_OPEN=4: inner_open=1.
  - EVACUATING=5: evacuating=1.
- Transitions:
  - LOW_IDLE:
    - outer_open_req=1 -> OUTER_OPEN. This has priority; a simultaneous fill_req is rejected.
    - Else fill_req -> FILLING with countdown=FILL_CYCLES-1.
    - inner_open_req is ignored.
    - evac_req -> reject.
  - OUTER_OPEN:
    - outer_open_req=0 -> LOW_IDLE.
    - fill_req or evac_req -> reject.
  - FILLING:
    - countdown decrements each cycle; at countdown==0 -> HIGH_IDLE.
    - evac_req -> abort: EVACUATING with countdown=min(FILL_CYCLES-1-countdown, EVAC_CYCLES-1). Elapsed fill time is reversed.
    - Door requests are ignored.
    - fill_req -> reject.
  - HIGH_IDLE: mirrors LOW_IDLE.
    - inner_open_req=1 -> INNER_OPEN. This has priority over evac_req, which is rejected.
    - Else evac_req -> EVACUATING with countdown=EVAC_CYCLES-1.
    - fill_req -> reject.
  - INNER_OPEN: mirrors OUTER_OPEN.
    - inner_open_req=0 -> HIGH_IDLE.
    - Pressure requests -> reject.
  - EVACUATING: mirrors FILLING.
    - At countdown==0 -> LOW_IDLE.
    - fill_req -> FILLING with countdown=min(EVAC_CYCLES-1-countdown, FILL_CYCLES-1).
    - evac_req -> reject.
- Countdown:
  - Is 0 in every non-timed state.
  - Never wraps below 0.
  - A timed op lasts exactly N cycles: N-1 down to 0 inclusive.
- Interlock invariants (must hold every cycle):
  - !(outer_open && inner_open).
  - No port is open while filling or evacuating.
- Occupancy:
  - boat_in/boat_out are accepted only in OUTER_OPEN or INNER_OPEN; in any other state they cause reject.
  - boat_in at MAX_OCC -> saturate, reject.
  - boat_out at 0 -> hold 0, reject.
  - boat_in and boat_out in the same cycle -> no change, no reject.
- reject:
  - Is the registered OR of all refusals in the cycle.
  - Multiple refusals in one cycle produce a single pulse.

Test Plan:
- Reset mid-FILLING (countdown=3) -> state_code=0, countdown=0, filling=0, occupancy=0 immediately, before the next clock edge.
- LOW_IDLE, fill_req pulse, defaults -> filling=1 for exactly 7 cycles with countdown 6..0, then state_code=3, filling=0.
- FILLING with countdown=2 (4 cycles elapsed), evac_req -> next cycle evacuating=1, countdown=4; LOW_IDLE reached 5 cycles later.
- LOW_IDLE with outer_open_req=1 and fill_req in the same cycle -> outer_open=1, reject=1 for one cycle, filling stays 0; an inner_open_req pulse never sets inner_open.
- OUTER_OPEN: three boat_in pulses -> occupancy 1, 2, 2 with reject on the third and occ_full=1. boat_in and boat_out together -> occupancy unchanged. boat_out in LOW_IDLE -> reject.
- Random request storm, 10k cycles -> outer_open&inner_open never 1; neither port is open while filling or evacuating.
